mmcm_div_gen: RTL

MMCM_DIV_GEN -- requirements
Module: mmcm_div_gen

---
 rtl/mmcm_div_gen.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/mmcm_div_gen.sv
// mmcm_div_gen: behavioural clock-divider generator modelled after an MMCM output stage.
//   Counts LOCK_CYCLES input cycles in LOCKING, then runs NUM_CH phase-aligned divided channels in LOCKED.
//   Latency: locked rises LOCK_CYCLES cycles after reset release or after an accepted reconfiguration.
//   Backpressure: cfg_ready is high only while LOCKED; an accepted valid channel write forces a relock.
// Ports:
//   clk_in1            sole clock, rising edge
//   reset              asynchronous active-high reset
//   clk_out[NUM_CH]    registered channel waveforms (all zero while LOCKING)
//   locked             registered, high while all channels run aligned
//   cfg_valid/cfg_ready/cfg_ch/cfg_divide/cfg_high/cfg_phase
//                      runtime reconfiguration port, present only when CLKGEN_DRP_EN is defined
// Optional feature macro: CLKGEN_DRP_EN (undefined -> configuration comes from parameters only).
module mmcm_div_gen #(
  parameter int NUM_CH      = 7,
  parameter int CNT_W       = 8,
  parameter int LOCK_CYCLES = 64,
  parameter logic [NUM_CH*CNT_W-1:0] DIVIDE_VEC = {NUM_CH{CNT_W'(10)}},
  parameter logic [NUM_CH*CNT_W-1:0] HIGH_VEC   = {NUM_CH{CNT_W'(5)}},
  parameter logic [NUM_CH*CNT_W-1:0] PHASE_VEC  = {NUM_CH{CNT_W'(0)}}
) (
  input  logic              clk_in1,
  input  logic              reset,
  output logic [NUM_CH-1:0] clk_out,
  output logic              locked
`ifdef CLKGEN_DRP_EN
  ,
  input  logic              cfg_valid,
  output logic              cfg_ready,
  input  logic [2:0]        cfg_ch,
  input  logic [CNT_W-1:0]  cfg_divide,
  input  logic [CNT_W-1:0]  cfg_high,
  input  logic [CNT_W-1:0]  cfg_phase
`endif
);

  localparam int LW = $clog2(LOCK_CYCLES + 1);

  typedef enum logic {
    LOCKING = 1'b0,
    LOCKED  = 1'b1
  } state_t;

  state_t            r_state;
  logic [LW-1:0]     r_lock_cnt;
  logic [CNT_W-1:0]  r_cnt [NUM_CH];
  logic [NUM_CH-1:0] r_clk_out;
  logic              r_locked;

  // Active configuration as seen by the channel counters.
  logic [CNT_W-1:0]  w_div   [NUM_CH];
  logic [CNT_W-1:0]  w_high  [NUM_CH];
  logic [CNT_W-1:0]  w_phase [NUM_CH];

  logic [CNT_W-1:0]  w_d_eff [NUM_CH];
  logic [CNT_W-1:0]  w_pmod  [NUM_CH];
  logic [CNT_W-1:0]  w_start [NUM_CH];
  logic [CNT_W-1:0]  w_nxt   [NUM_CH];
  logic [NUM_CH-1:0] w_start_out;
  logic [NUM_CH-1:0] w_nxt_out;
  logic              w_xfer;

`ifdef CLKGEN_DRP_EN
  logic [CNT_W-1:0]  r_div   [NUM_CH];
  logic [CNT_W-1:0]  r_high  [NUM_CH];
  logic [CNT_W-1:0]  r_phase [NUM_CH];
  logic              w_ch_ok;

  assign w_ch_ok   = ({1'b0, cfg_ch} < 4'(NUM_CH));
  // Out-of-range channel requests are consumed but change nothing.
  assign w_xfer    = cfg_valid && r_locked && w_ch_ok;
  assign cfg_ready = r_locked;

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        r_div[i]   <= DIVIDE_VEC[i*CNT_W +: CNT_W];
        r_high[i]  <= HIGH_VEC[i*CNT_W +: CNT_W];
        r_phase[i] <= PHASE_VEC[i*CNT_W +: CNT_W];
      end
    end else if (w_xfer) begin
      for (int i = 0; i < NUM_CH; i++) begin
        if (cfg_ch == 3'(i)) begin
          r_div[i]   <= cfg_divide;
          r_high[i]  <= cfg_high;
          r_phase[i] <= cfg_phase;
        end
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_div[i]   = r_div[i];
      w_high[i]  = r_high[i];
      w_phase[i] = r_phase[i];
    end
  end
`else
  assign w_xfer = 1'b0;

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      w_div[i]   = DIVIDE_VEC[i*CNT_W +: CNT_W];
      w_high[i]  = HIGH_VEC[i*CNT_W +: CNT_W];
      w_phase[i] = PHASE_VEC[i*CNT_W +: CNT_W];
    end
  end
`endif

  // Per-channel counter holds (t - P) mod D for the cycle being shown on clk_out.
  // The start value at t=0 is (-P) mod D; the output is simply count < high, which
  // yields constant low for H=0 and constant high for H>=D without special cases.
  always_comb begin
    w_start_out = '0;
    w_nxt_out   = '0;
    for (int i = 0; i < NUM_CH; i++) begin
      w_d_eff[i] = (w_div[i] == '0) ? CNT_W'(1) : w_div[i];
      w_pmod[i]  = w_phase[i] % w_d_eff[i];
      w_start[i] = (w_pmod[i] == '0) ? '0 : (w_d_eff[i] - w_pmod[i]);
      w_nxt[i]   = (r_cnt[i] == (w_d_eff[i] - CNT_W'(1))) ? '0 : (r_cnt[i] + CNT_W'(1));
      w_start_out[i] = (w_start[i] < w_high[i]);
      w_nxt_out[i]   = (w_nxt[i] < w_high[i]);
    end
  end

  always_ff @(posedge clk_in1 or posedge reset) begin
    if (reset) begin
      r_state    <= LOCKING;
      r_lock_cnt <= '0;
      r_locked   <= 1'b0;
      r_clk_out  <= '0;
      for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
    end else begin
      case (r_state)
        LOCKING: begin
          if (r_lock_cnt == LW'(LOCK_CYCLES - 1)) begin
            // All channels start together at t=0 on this edge.
            r_state   <= LOCKED;
            r_locked  <= 1'b1;
            r_clk_out <= w_start_out;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_start[i];
          end else begin
            r_lock_cnt <= r_lock_cnt + LW'(1);
          end
        end
        LOCKED: begin
          if (w_xfer) begin
            r_state    <= LOCKING;
            r_lock_cnt <= '0;
            r_locked   <= 1'b0;
            r_clk_out  <= '0;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= '0;
          end else begin
            r_clk_out <= w_nxt_out;
            for (int i = 0; i < NUM_CH; i++) r_cnt[i] <= w_nxt[i];
          end
        end
        default: begin
          r_state    <= LOCKING;
          r_lock_cnt <= '0;
          r_locked   <= 1'b0;
          r_clk_out  <= '0;
        end
      endcase
    end
  end

  assign clk_out = r_clk_out;
  assign locked  = r_locked;

endmodule
